// File: rtl/train_batch_scheduler_pkg.sv
// Shared encodings and defaults for the mini-batch scheduler.
package train_batch_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_WAIT_FIN = 3'd2,
        S_ADVANCE  = 3'd3,
        S_DRAIN    = 3'd4,
        S_FINISH   = 3'd5
    } sched_state_e;

    localparam int unsigned SCHED_TIMEOUT_DEF = 32'h0010_0000;

endpackage

// File: rtl/train_batch_scheduler_watchdog.sv
// Down-counting watchdog for the per-sample wait; reloads on clear, fires at zero while enabled.
module sched_watchdog #(
    parameter int          TO_W    = 24,
    parameter int unsigned TIMEOUT = 32'h0010_0000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TO_W-1:0] LOAD = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = LOAD;
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Count reaches zero on the TIMEOUT-th cycle spent waiting.
    assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/train_batch_scheduler.sv
// Mini-batch sequencer: one run/next pair per sample, sample/batch counters, gradient
// accumulate/update flags, abort handling and a stall watchdog on the main FSM.
module train_batch_scheduler
    import train_batch_scheduler_pkg::*;
#(
    parameter int          BATCH_W = 8,
    parameter int          ITER_W  = 16,
    parameter int          TO_W    = 24,
    parameter int unsigned TIMEOUT = SCHED_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [BATCH_W-1:0] batch_size,
    input  logic [ITER_W-1:0]  num_batches,
    input  logic               main_fin,
    input  logic               main_idle,
    output logic               run,
    output logic               next,
    output logic               grad_keep,
    output logic               upd_en,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               err,
    output logic [BATCH_W-1:0] sample_idx,
    output logic [ITER_W-1:0]  batch_idx
);

    sched_state_e       state_q, state_d;
    logic [BATCH_W-1:0] bs_q, bs_d, sidx_q, sidx_d;
    logic [ITER_W-1:0]  nb_q, nb_d, bidx_q, bidx_d;
    logic               err_q, err_d, abrt_q, abrt_d, pend_q, pend_d;
    logic               gk_q, gk_d, ue_q, ue_d;
    logic               wd_clr, wd_en, wd_exp;
    logic               last_s, last_b, stop_req;

    sched_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_exp)
    );

    assign last_s   = (sidx_q == bs_q - 1'b1);
    assign last_b   = (bidx_q == nb_q - 1'b1);
    // An abort arriving in the same cycle as the decision still stops the job.
    assign stop_req = pend_q | abort;

    always_comb begin
        state_d = state_q;
        bs_d    = bs_q;
        nb_d    = nb_q;
        sidx_d  = sidx_q;
        bidx_d  = bidx_q;
        err_d   = err_q;
        abrt_d  = abrt_q;
        pend_d  = pend_q;
        gk_d    = gk_q;
        ue_d    = ue_q;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;

        if (abort && state_q != S_IDLE && state_q != S_FINISH)
            pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    bs_d   = batch_size;
                    nb_d   = num_batches;
                    sidx_d = '0;
                    bidx_d = '0;
                    err_d  = 1'b0;
                    abrt_d = 1'b0;
                    pend_d = 1'b0;
                    if (batch_size == '0 || num_batches == '0) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                wd_clr  = 1'b1;
                state_d = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                wd_en = 1'b1;
                if (main_fin) begin
                    state_d = S_ADVANCE;
                end else if (wd_exp) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_ADVANCE: begin
                if (last_s) begin
                    sidx_d = '0;
                    bidx_d = bidx_q + 1'b1;
                end else begin
                    sidx_d = sidx_q + 1'b1;
                end
                if (stop_req || (last_s && last_b)) begin
                    abrt_d  = abrt_q | stop_req;
                    state_d = S_FINISH;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (stop_req) begin
                    abrt_d  = 1'b1;
                    state_d = S_FINISH;
                end else if (main_idle) begin
                    state_d = S_LAUNCH;
                end
            end
            S_FINISH: begin
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flags are captured for the sample about to launch and held through its ADVANCE.
        if (state_d == S_LAUNCH) begin
            gk_d = (sidx_d != '0);
            ue_d = (sidx_d == bs_d - 1'b1);
        end else if (state_d == S_IDLE) begin
            gk_d = 1'b0;
            ue_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bs_q    <= '0;
            nb_q    <= '0;
            sidx_q  <= '0;
            bidx_q  <= '0;
            err_q   <= 1'b0;
            abrt_q  <= 1'b0;
            pend_q  <= 1'b0;
            gk_q    <= 1'b0;
            ue_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bs_q    <= bs_d;
            nb_q    <= nb_d;
            sidx_q  <= sidx_d;
            bidx_q  <= bidx_d;
            err_q   <= err_d;
            abrt_q  <= abrt_d;
            pend_q  <= pend_d;
            gk_q    <= gk_d;
            ue_q    <= ue_d;
        end
    end

    assign run        = (state_q == S_LAUNCH);
    assign next       = (state_q == S_ADVANCE);
    assign done       = (state_q == S_FINISH);
    assign busy       = (state_q != S_IDLE);
    assign grad_keep  = gk_q;
    assign upd_en     = ue_q;
    assign aborted    = abrt_q;
    assign err        = err_q;
    assign sample_idx = sidx_q;
    assign batch_idx  = bidx_q;

endmodule

// File: tb/tb_train_batch_scheduler.sv
// Bench for train_batch_scheduler: cycle-exact vector table plus job-level sequences.
module tb_train_batch_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, main_fin, main_idle;
    logic [7:0]  batch_size;
    logic [15:0] num_batches;
    logic        run, next, grad_keep, upd_en, busy, done, aborted, err;
    logic [7:0]  sample_idx;
    logic [15:0] batch_idx;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    train_batch_scheduler #(
        .BATCH_W (8),
        .ITER_W  (16),
        .TO_W    (24),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .batch_size  (batch_size),
        .num_batches (num_batches),
        .main_fin    (main_fin),
        .main_idle   (main_idle),
        .run         (run),
        .next        (next),
        .grad_keep   (grad_keep),
        .upd_en      (upd_en),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .err         (err),
        .sample_idx  (sample_idx),
        .batch_idx   (batch_idx)
    );

    // {run,next,grad_keep,upd_en,busy,done,aborted,err, sample_idx, batch_idx}
    function automatic logic [31:0] outs();
        return {run, next, grad_keep, upd_en, busy, done, aborted, err, sample_idx, batch_idx};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        st, ab, fin, idl;
        logic [7:0]  bs;
        logic [15:0] nb;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic st, ab, fin, idl, input logic [7:0] bs,
                                input logic [15:0] nb, input logic [7:0] flags,
                                input logic [7:0] s, input logic [15:0] b);
        vec_t v;
        v.st = st; v.ab = ab; v.fin = fin; v.idl = idl; v.bs = bs; v.nb = nb;
        v.exp = {flags, s, b};
        return v;
    endfunction

    // Starts a job and plays the main FSM: main_fin fin_dly cycles after each run (0 = never),
    // optional abort/start pulse 2 cycles after run number abort_at/start_at, optional
    // main_idle low for idle_hold cycles after each next.
    task automatic run_job(input int bs, nb, fin_dly, abort_at, start_at, idle_hold,
                           output int runs, nexts, first_run, done_cyc, last_next, gap,
                           output logic [7:0] gks, ues, output logic ok, fin_err, fin_ab,
                           output logic [15:0] fin_bidx);
        int fcnt, acnt, scnt, icnt;
        @(posedge clk); #1;
        batch_size = 8'(bs); num_batches = 16'(nb);
        start = 1'b1; abort = 1'b0; main_fin = 1'b0; main_idle = 1'b1;
        runs = 0; nexts = 0; first_run = -1; done_cyc = -1; last_next = -1; gap = 0;
        gks = '0; ues = '0; ok = 1'b0; fin_err = 1'b0; fin_ab = 1'b0; fin_bidx = '0;
        fcnt = 0; acnt = 0; scnt = 0; icnt = 0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            if (fcnt > 0) begin fcnt--; if (fcnt == 0) main_fin = 1'b1; end
            if (acnt > 0) begin acnt--; if (acnt == 0) abort = 1'b1; end
            if (scnt > 0) begin
                scnt--;
                if (scnt == 0) begin start = 1'b1; batch_size = 8'd1; num_batches = 16'd1; end
            end
            if (icnt > 0) begin icnt--; if (icnt == 0) main_idle = 1'b1; end
            if (run) begin
                if (runs == 0) first_run = c;
                else if (c - last_next > gap) gap = c - last_next;
                runs++;
                fcnt = fin_dly;
                if (runs == abort_at) acnt = 2;
                if (runs == start_at) scnt = 2;
            end
            if (next) begin
                if (nexts < 8) begin gks[nexts] = grad_keep; ues[nexts] = upd_en; end
                nexts++;
                last_next = c;
                main_fin = 1'b0;
                if (idle_hold > 0) begin main_idle = 1'b0; icnt = idle_hold; end
            end
            if (done) begin
                done_cyc = c; ok = 1'b1;
                fin_err = err; fin_ab = aborted; fin_bidx = batch_idx;
                break;
            end
        end
        start = 1'b0; abort = 1'b0; main_fin = 1'b0; main_idle = 1'b1;
    endtask

    int runs, nexts, fr, dc, ln, gap;
    logic [7:0] gks, ues;
    logic ok, ferr, fab, quiet;
    logic [15:0] fbidx;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; main_fin = 1'b0; main_idle = 1'b1;
        batch_size = '0; num_batches = '0;
        #1;
        chk("reset_outs", outs(), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        //            st ab fin idl bs nb   flags         sidx bidx
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 8'b0000_0000, 0, 0));
        tv.push_back(mk(1, 0, 0, 1, 0, 3, 8'b0000_1101, 0, 0)); // zero batch_size
        tv.push_back(mk(0, 0, 0, 1, 0, 3, 8'b0000_0001, 0, 0));
        tv.push_back(mk(1, 1, 0, 1, 1, 1, 8'b0000_0001, 0, 0)); // start+abort dropped
        tv.push_back(mk(1, 0, 0, 1, 1, 1, 8'b1001_1000, 0, 0)); // bs=1 launch
        tv.push_back(mk(0, 0, 1, 1, 1, 1, 8'b0001_1000, 0, 0)); // fin during LAUNCH ignored
        tv.push_back(mk(0, 0, 1, 1, 1, 1, 8'b0101_1000, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 1, 1, 8'b0001_1100, 0, 1));
        tv.push_back(mk(0, 0, 0, 1, 1, 1, 8'b0000_0000, 0, 1));
        tv.push_back(mk(1, 0, 0, 1, 2, 1, 8'b1000_1000, 0, 0)); // bs=2
        tv.push_back(mk(0, 0, 1, 1, 2, 1, 8'b0000_1000, 0, 0));
        tv.push_back(mk(0, 0, 1, 1, 2, 1, 8'b0100_1000, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 2, 1, 8'b0000_1000, 1, 0)); // drain, idle low
        tv.push_back(mk(0, 0, 0, 0, 2, 1, 8'b0000_1000, 1, 0));
        tv.push_back(mk(0, 0, 0, 1, 2, 1, 8'b1011_1000, 1, 0));
        tv.push_back(mk(0, 0, 1, 1, 2, 1, 8'b0011_1000, 1, 0));
        tv.push_back(mk(0, 0, 1, 1, 2, 1, 8'b0111_1000, 1, 0));
        tv.push_back(mk(0, 0, 0, 1, 2, 1, 8'b0011_1100, 0, 1));
        tv.push_back(mk(0, 0, 0, 1, 2, 1, 8'b0000_0000, 0, 1));
        tv.push_back(mk(0, 1, 0, 1, 1, 1, 8'b0000_0000, 0, 1)); // abort in IDLE ignored
        tv.push_back(mk(1, 0, 0, 1, 1, 1, 8'b1001_1000, 0, 0));
        tv.push_back(mk(0, 0, 1, 1, 1, 1, 8'b0001_1000, 0, 0));
        tv.push_back(mk(0, 0, 1, 1, 1, 1, 8'b0101_1000, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 1, 1, 8'b0001_1100, 0, 1));
        tv.push_back(mk(0, 0, 0, 1, 1, 1, 8'b0000_0000, 0, 1));
        tv.push_back(mk(1, 0, 0, 1, 2, 1, 8'b1000_1000, 0, 0)); // abort in WAIT_FIN
        tv.push_back(mk(0, 0, 1, 1, 2, 1, 8'b0000_1000, 0, 0));
        tv.push_back(mk(0, 1, 1, 1, 2, 1, 8'b0100_1000, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 2, 1, 8'b0000_1110, 1, 0));
        tv.push_back(mk(0, 0, 0, 1, 2, 1, 8'b0000_0010, 1, 0));

        for (int i = 0; i < tv.size(); i++) begin
            start = tv[i].st; abort = tv[i].ab; main_fin = tv[i].fin; main_idle = tv[i].idl;
            batch_size = tv[i].bs; num_batches = tv[i].nb;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), outs(), tv[i].exp);
        end
        start = 1'b0; abort = 1'b0; main_fin = 1'b0; main_idle = 1'b1;

        // Full job: 2x2, fin 5 cycles after each run.
        run_job(2, 2, 5, 0, 0, 0, runs, nexts, fr, dc, ln, gap, gks, ues, ok, ferr, fab, fbidx);
        chk("jobA_done", ok, 1);
        chk("jobA_runs", runs, 4);
        chk("jobA_nexts", nexts, 4);
        chk("jobA_gk", gks[3:0], 4'b1010);
        chk("jobA_ue", ues[3:0], 4'b1010);
        chk("jobA_done_gap", dc - ln, 1);
        chk("jobA_drain_gap", gap, 2);
        chk("jobA_flags", {ferr, fab}, 2'b00);
        chk("jobA_bidx", fbidx, 2);

        // Same job with a stray start in WAIT_FIN and main_idle held low 10 cycles in DRAIN.
        run_job(2, 2, 5, 0, 1, 10, runs, nexts, fr, dc, ln, gap, gks, ues, ok, ferr, fab, fbidx);
        chk("jobB_done", ok, 1);
        chk("jobB_runs", runs, 4);
        chk("jobB_ue", ues[3:0], 4'b1010);
        chk("jobB_gk", gks[3:0], 4'b1010);
        chk("jobB_drain_gap", gap, 11);

        // Abort during the 2nd WAIT_FIN of a 3-sample batch.
        run_job(3, 1, 5, 2, 0, 0, runs, nexts, fr, dc, ln, gap, gks, ues, ok, ferr, fab, fbidx);
        chk("jobC_done", ok, 1);
        chk("jobC_runs", runs, 2);
        chk("jobC_nexts", nexts, 2);
        chk("jobC_done_gap", dc - ln, 1);
        chk("jobC_flags", {ferr, fab}, 2'b01);
        chk("jobC_ue", ues[1:0], 2'b00);

        // Watchdog: main_fin never returns.
        run_job(1, 1, 0, 0, 0, 0, runs, nexts, fr, dc, ln, gap, gks, ues, ok, ferr, fab, fbidx);
        chk("jobD_done", ok, 1);
        chk("jobD_runs", runs, 1);
        chk("jobD_nexts", nexts, 0);
        chk("jobD_timeout", dc - fr, 17);
        chk("jobD_flags", {ferr, fab}, 2'b10);

        // A valid start clears the sticky error.
        run_job(1, 1, 5, 0, 0, 0, runs, nexts, fr, dc, ln, gap, gks, ues, ok, ferr, fab, fbidx);
        chk("jobE_done", ok, 1);
        chk("jobE_flags", {ferr, fab}, 2'b00);
        chk("jobE_gkue", {gks[0], ues[0]}, 2'b01);

        // Reset mid-WAIT_FIN of the 2nd batch.
        @(posedge clk); #1;
        batch_size = 8'd1; num_batches = 16'd3; main_fin = 1'b1; main_idle = 1'b1; start = 1'b1;
        repeat (5) begin @(posedge clk); #1; start = 1'b0; end
        main_fin = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset", outs(), {8'b0001_1000, 8'd0, 16'd1});
        #2 rst_n = 1'b0;
        #1 chk("async_reset", outs(), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        quiet = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) quiet = 1'b1;
        end
        chk("post_reset_quiet", quiet, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
